// File: rtl/hssim_map_aligner.sv
// rtl/hssim_map_aligner.sv - aligns old/avg/new map beat streams for HSSIM and tracks frame position
// Three per-stream FIFOs pop together only when all hold a beat and downstream is ready.

module hssim_map_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] in_tdata,
  input  logic             in_tvalid,
  output logic             in_tready,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full, push, do_pop;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  // No push-through when full, even if a pop happens in the same cycle.
  assign in_tready = !full;
  assign push      = in_tvalid && !full;
  assign do_pop    = pop && !empty;
  assign head      = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
    if (push) begin
      mem_d[wr_ptr_q] = in_tdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

module hssim_map_aligner #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int INPUT_WIDTH     = 8,
  parameter int DATA_WIDTH      = INPUT_WIDTH * PIXELS_PER_BEAT,
  parameter int IMAGE_DIM       = 512,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_old_tdata,
  input  logic                  s_old_tvalid,
  output logic                  s_old_tready,
  input  logic [DATA_WIDTH-1:0] s_avg_tdata,
  input  logic                  s_avg_tvalid,
  output logic                  s_avg_tready,
  input  logic [DATA_WIDTH-1:0] s_new_tdata,
  input  logic                  s_new_tvalid,
  output logic                  s_new_tready,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] old_map,
  output logic [DATA_WIDTH-1:0] avg_map,
  output logic [DATA_WIDTH-1:0] new_map,
  output logic                  stall,
  output logic                  sof,
  output logic                  eol,
  output logic                  eof,
  output logic                  frame_done
);
  localparam int BPR = IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int CW  = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int RW  = (IMAGE_DIM > 1) ? $clog2(IMAGE_DIM) : 1;

  logic          old_empty, avg_empty, new_empty, fire;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          frame_done_q, frame_done_d;

  assign fire  = !old_empty && !avg_empty && !new_empty && out_ready;
  assign stall = !fire;

  hssim_map_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_old_fifo (
    .clk(clk), .aresetn(aresetn), .in_tdata(s_old_tdata), .in_tvalid(s_old_tvalid),
    .in_tready(s_old_tready), .pop(fire), .head(old_map), .empty(old_empty)
  );

  hssim_map_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_avg_fifo (
    .clk(clk), .aresetn(aresetn), .in_tdata(s_avg_tdata), .in_tvalid(s_avg_tvalid),
    .in_tready(s_avg_tready), .pop(fire), .head(avg_map), .empty(avg_empty)
  );

  hssim_map_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_new_fifo (
    .clk(clk), .aresetn(aresetn), .in_tdata(s_new_tdata), .in_tvalid(s_new_tvalid),
    .in_tready(s_new_tready), .pop(fire), .head(new_map), .empty(new_empty)
  );

  assign sof        = (row_q == '0) && (col_q == '0);
  assign eol        = (col_q == CW'(BPR - 1));
  assign eof        = eol && (row_q == RW'(IMAGE_DIM - 1));
  assign frame_done = frame_done_q;

  // Position advances only on a transferred triple.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = fire && eof;
    if (fire) begin
      if (eol) begin
        col_d = '0;
        row_d = eof ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_hssim_map_aligner.sv
// tb/tb_hssim_map_aligner.sv - self-checking bench for hssim_map_aligner
// Queue-based reference model plus a hand-computed handshake vector table.

module tb_hssim_map_aligner;
  localparam int PPB   = 16;
  localparam int DW    = 128;
  localparam int DIM   = 512;
  localparam int BPR   = DIM / PPB;
  localparam int FRAME = BPR * DIM;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_old_tdata = '0, s_avg_tdata = '0, s_new_tdata = '0;
  logic          s_old_tvalid = 1'b0, s_avg_tvalid = 1'b0, s_new_tvalid = 1'b0;
  logic          s_old_tready, s_avg_tready, s_new_tready;
  logic          out_ready = 1'b0;
  logic [DW-1:0] old_map, avg_map, new_map;
  logic          stall, sof, eol, eof, frame_done;

  always #5 clk = ~clk;

  hssim_map_aligner dut (
    .clk(clk), .aresetn(aresetn),
    .s_old_tdata(s_old_tdata), .s_old_tvalid(s_old_tvalid), .s_old_tready(s_old_tready),
    .s_avg_tdata(s_avg_tdata), .s_avg_tvalid(s_avg_tvalid), .s_avg_tready(s_avg_tready),
    .s_new_tdata(s_new_tdata), .s_new_tvalid(s_new_tvalid), .s_new_tready(s_new_tready),
    .out_ready(out_ready), .old_map(old_map), .avg_map(avg_map), .new_map(new_map),
    .stall(stall), .sof(sof), .eol(eol), .eof(eof), .frame_done(frame_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] q_old[$], q_avg[$], q_new[$];
  int            k_old, k_avg, k_new;
  int            pos;
  bit            fd_exp;

  typedef struct packed {
    bit       vo, va, vn, rdy;
    bit [3:0] exp_hs;
  } vec_t;

  function automatic logic [DW-1:0] beat(input int k, input int off);
    logic [7:0] p;
    p = 8'(k + off);
    return {PPB{p}};
  endfunction

  task automatic chk(input string name, input logic [383:0] got, input logic [383:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    q_old.delete(); q_avg.delete(); q_new.delete();
    k_old = 0; k_avg = 0; k_new = 0;
    pos = 0; fd_exp = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_old_tvalid = 1'b0; s_avg_tvalid = 1'b0; s_new_tvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("reset_handshake", 384'({stall, s_old_tready, s_avg_tready, s_new_tready}), 384'(4'b1111));
    chk("reset_maps", 384'({old_map, avg_map, new_map}), 384'(0));
    chk("reset_flags", 384'({sof, eol, eof, frame_done}), 384'(4'b1000));
    model_reset();
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  // One clock: drive at negedge, sample 1ns later, advance model at posedge.
  task automatic cycle(input bit vo, input bit va, input bit vn, input bit rdy,
                       output bit f, output logic [3:0] hs, output logic [4:0] fl);
    bit tro, tra, trn, last;
    logic [DW-1:0] eo, ea, en;
    @(negedge clk);
    s_old_tvalid = vo; s_avg_tvalid = va; s_new_tvalid = vn; out_ready = rdy;
    s_old_tdata = beat(k_old, 0); s_avg_tdata = beat(k_avg, 1); s_new_tdata = beat(k_new, 2);
    #1;
    tro = q_old.size() < DEPTH;
    tra = q_avg.size() < DEPTH;
    trn = q_new.size() < DEPTH;
    f = (q_old.size() > 0) && (q_avg.size() > 0) && (q_new.size() > 0) && rdy;
    eo = (q_old.size() > 0) ? q_old[0] : '0;
    ea = (q_avg.size() > 0) ? q_avg[0] : '0;
    en = (q_new.size() > 0) ? q_new[0] : '0;
    last = (pos == FRAME - 1);
    hs = {stall, s_old_tready, s_avg_tready, s_new_tready};
    fl = {stall, sof, eol, eof, frame_done};
    chk("handshake", 384'(hs), 384'({!f, tro, tra, trn}));
    chk("maps", {old_map, avg_map, new_map}, {eo, ea, en});
    chk("flags", 384'({sof, eol, eof, frame_done}),
        384'({pos == 0, (pos % BPR) == BPR - 1, last, fd_exp}));
    if (f)
      chk("align", 384'({avg_map[7:0] - old_map[7:0], new_map[7:0] - old_map[7:0]}),
          384'({8'd1, 8'd2}));
    @(posedge clk);
    fd_exp = f && last;
    if (f) begin
      void'(q_old.pop_front()); void'(q_avg.pop_front()); void'(q_new.pop_front());
      pos = (pos + 1) % FRAME;
    end
    if (vo && tro) begin q_old.push_back(beat(k_old, 0)); k_old++; end
    if (va && tra) begin q_avg.push_back(beat(k_avg, 1)); k_avg++; end
    if (vn && trn) begin q_new.push_back(beat(k_new, 2)); k_new++; end
  endtask

  initial begin
    vec_t       tbl[12];
    bit         f;
    logic [3:0] hs;
    logic [4:0] fl;
    int         nf, eol_cnt, eof_at, fd_cnt, guard;
    bit         sof_next, seen;

    // {vo, va, vn, rdy, {stall, tready_old, tready_avg, tready_new}}
    tbl[0]  = '{1, 1, 1, 1, 4'b1111};
    tbl[1]  = '{1, 1, 0, 1, 4'b0111};
    tbl[2]  = '{1, 1, 0, 1, 4'b1111};
    tbl[3]  = '{1, 1, 0, 1, 4'b1111};
    tbl[4]  = '{1, 1, 0, 1, 4'b1111};
    tbl[5]  = '{1, 1, 0, 1, 4'b1001};
    tbl[6]  = '{1, 1, 1, 1, 4'b1001};
    tbl[7]  = '{1, 1, 1, 1, 4'b0001};
    tbl[8]  = '{1, 1, 1, 1, 4'b0111};
    tbl[9]  = '{1, 1, 1, 1, 4'b0111};
    tbl[10] = '{1, 1, 1, 0, 4'b1111};
    tbl[11] = '{1, 1, 1, 0, 4'b1001};

    model_reset();
    do_reset();

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].vo, tbl[i].va, tbl[i].vn, tbl[i].rdy, f, hs, fl);
      chk($sformatf("vector_%0d", i), 384'(hs), 384'(tbl[i].exp_hs));
    end
    for (int i = 0; i < 20; i++) cycle(1, 1, 1, 1, f, hs, fl);

    do_reset();
    nf = 0;
    for (int i = 0; i < 5000 && nf < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, f, hs, fl);
      if (f) nf++;
    end
    chk("random_done", 384'(nf >= 400), 384'(1));
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, f, hs, fl);
    chk("random_drained", 384'(stall), 384'(1));

    do_reset();
    nf = 0; eol_cnt = 0; eof_at = -1; fd_cnt = 0; sof_next = 1'b0;
    for (int i = 0; i < FRAME + 3; i++) begin
      cycle(1, 1, 1, 1, f, hs, fl);
      if (fl[0]) fd_cnt++;
      if (!fl[4]) begin
        if (fl[2]) eol_cnt++;
        if (fl[1]) eof_at = nf;
        if (nf == FRAME) sof_next = fl[3];
        nf++;
      end
    end
    chk("eol_count", 384'(eol_cnt), 384'(BPR * DIM / BPR));
    chk("eof_index", 384'(eof_at), 384'(FRAME - 1));
    chk("frame_done_count", 384'(fd_cnt), 384'(1));
    chk("sof_after_eof", 384'(sof_next), 384'(1));

    guard = 0;
    while (pos != 3 * BPR + 10 && guard < 20000) begin
      cycle(1, 1, 1, 1, f, hs, fl);
      guard++;
    end
    chk("reach_row3_col10", 384'(pos), 384'(3 * BPR + 10));
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 1, 1, f, hs, fl);
      if (!fl[4] && !seen) begin
        seen = 1'b1;
        chk("sof_after_reset", 384'(fl[3]), 384'(1));
        chk("first_map_after_reset", 384'(old_map[7:0]), 384'(0));
      end
    end
    chk("fire_after_reset", 384'(seen), 384'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
